// File: rtl/msg_rom_scheduler_if.sv
// Bundle between the message scheduler, its two requesters, the shared ROM
// and the byte consumer. The scheduler uses the master view.
interface msg_rom_scheduler_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4
);
  logic [1:0]        REQ;
  logic [ADDR_W-1:0] BASE0;
  logic [LEN_W-1:0]  LEN0;
  logic [ADDR_W-1:0] BASE1;
  logic [LEN_W-1:0]  LEN1;
  logic [1:0]        GNT;
  logic [ADDR_W-1:0] ROM_ADDR;
  logic [DATA_W-1:0] ROM_DOUT;
  logic [DATA_W-1:0] OUT;
  logic              OUT_VALID;
  logic              OUT_READY;
  logic              OUT_LAST;
  logic              OUT_ID;
  logic              DONE;
  logic              BUSY;

  modport master (
    input  REQ, BASE0, LEN0, BASE1, LEN1, ROM_DOUT, OUT_READY,
    output GNT, ROM_ADDR, OUT, OUT_VALID, OUT_LAST, OUT_ID, DONE, BUSY
  );

  modport slave (
    output REQ, BASE0, LEN0, BASE1, LEN1, ROM_DOUT, OUT_READY,
    input  GNT, ROM_ADDR, OUT, OUT_VALID, OUT_LAST, OUT_ID, DONE, BUSY
  );
endinterface

// File: rtl/msg_rom_scheduler.sv
// Round-robin sharing of one synchronous message ROM between two requesters;
// each granted message is streamed top address first on a valid/ready port.
module msg_rom_scheduler #(
  parameter int ADDR_W = 4,
  parameter int LEN_W  = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  msg_rom_scheduler_if.master bus
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, SEND} state_t;

  state_t            state;
  logic              rr_ptr;
  logic              done_pending;
  logic              win;
  logic [LEN_W-1:0]  remaining;
  logic [LEN_W-1:0]  sel_len;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] sel_base;

  // A lone requester wins outright; a tie goes to whoever rr_ptr favours.
  always_comb begin
    win      = (bus.REQ == 2'b11) ? rr_ptr : bus.REQ[1];
    sel_base = win ? bus.BASE1 : bus.BASE0;
    sel_len  = win ? bus.LEN1  : bus.LEN0;
  end

  assign bus.BUSY = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      rr_ptr        <= 1'b0;
      done_pending  <= 1'b0;
      remaining     <= '0;
      addr          <= '0;
      bus.GNT       <= '0;
      bus.ROM_ADDR  <= '0;
      bus.OUT       <= '0;
      bus.OUT_VALID <= 1'b0;
      bus.OUT_LAST  <= 1'b0;
      bus.OUT_ID    <= 1'b0;
      bus.DONE      <= 1'b0;
    end else begin
      bus.GNT      <= '0;
      bus.DONE     <= done_pending;
      done_pending <= 1'b0;
      case (state)
        IDLE: begin
          if (|bus.REQ) begin
            bus.GNT    <= win ? 2'b10 : 2'b01;
            bus.OUT_ID <= win;
            rr_ptr     <= ~win;
            remaining  <= sel_len;
            addr       <= sel_base + ADDR_W'(sel_len) - ADDR_W'(1);
            // An empty message completes one cycle later without touching the ROM.
            if (sel_len == '0) begin
              done_pending <= 1'b1;
            end else begin
              state <= ADDR;
            end
          end
        end
        ADDR: begin
          bus.ROM_ADDR <= addr;
          state        <= DATA;
        end
        DATA: begin
          bus.OUT       <= bus.ROM_DOUT;
          bus.OUT_VALID <= 1'b1;
          bus.OUT_LAST  <= (remaining == LEN_W'(1));
          remaining     <= remaining - LEN_W'(1);
          addr          <= addr - ADDR_W'(1);
          state         <= SEND;
        end
        SEND: begin
          if (bus.OUT_READY) begin
            bus.OUT_VALID <= 1'b0;
            bus.OUT_LAST  <= 1'b0;
            if (remaining == '0) begin
              bus.DONE <= 1'b1;
              state    <= IDLE;
            end else begin
              state <= ADDR;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_msg_rom_scheduler.sv
// Directed bench for msg_rom_scheduler: a table of message requests with
// hand-computed byte streams, plus reset and mid-message reset sequences.
module tb_msg_rom_scheduler;

  typedef logic [3:0][7:0] bytes_t;

  typedef struct {
    logic [1:0] req;
    logic [3:0] base0;
    logic [3:0] len0;
    logic [3:0] base1;
    logic [3:0] len1;
    logic       hold;
    logic [1:0] exp_gnt;
    int         exp_len;
    bytes_t     exp_bytes;
    int         stall_at;
    int         stall_n;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   num_checks = 0;
  int   num_fail   = 0;

  logic [7:0] rom [16];
  vec_t       vecs [11];
  vec_t       restart_vec;

  always #5 clk = ~clk;

  msg_rom_scheduler_if #(.ADDR_W(4), .DATA_W(8), .LEN_W(4)) bus ();

  msg_rom_scheduler #(.ADDR_W(4), .LEN_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.ROM_DOUT = rom[bus.ROM_ADDR];

  function automatic bytes_t seq(input logic [7:0] a, input logic [7:0] b,
                                 input logic [7:0] c, input logic [7:0] d);
    seq = {d, c, b, a};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    num_checks++;
    if (act !== exp) begin
      num_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one request, then follows the message to DONE, checking every byte.
  task automatic applyStimulus(input vec_t v);
    int         k;
    int         stalled;
    int         last_hs;
    bit         got;
    logic [3:0] b;
    logic [3:0] l;
    logic [3:0] ea;
    bus.REQ       = v.req;
    bus.BASE0     = v.base0;
    bus.LEN0      = v.len0;
    bus.BASE1     = v.base1;
    bus.LEN1      = v.len1;
    bus.OUT_READY = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.GNT != 2'b00) begin
        got = 1'b1;
        break;
      end
    end
    checkOutput("gnt", 32'(bus.GNT), 32'(v.exp_gnt));
    if (!got) return;
    checkOutput("gnt_id", 32'(bus.OUT_ID), 32'(v.exp_gnt[1]));
    if (!v.hold) bus.REQ = 2'b00;
    b       = v.exp_gnt[1] ? v.base1 : v.base0;
    l       = v.exp_gnt[1] ? v.len1 : v.len0;
    k       = 0;
    stalled = 0;
    last_hs = -10;
    got     = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (bus.DONE) begin
        checkOutput("done_count", 32'(k), 32'(v.exp_len));
        checkOutput("done_id", 32'(bus.OUT_ID), 32'(v.exp_gnt[1]));
        checkOutput("done_busy", 32'(bus.BUSY), 32'(0));
        checkOutput("done_timing", 32'(c), 32'((v.exp_len == 0) ? 1 : last_hs + 1));
        got = 1'b1;
        break;
      end
      checkOutput("gnt_quiet", 32'(bus.GNT), 32'(0));
      if (bus.OUT_VALID) begin
        if (k >= v.exp_len) begin
          checkOutput("extra_byte", 32'(k), 32'(v.exp_len));
          bus.OUT_READY = 1'b1;
          k++;
        end else begin
          ea = b + l - 4'(k) - 4'd1;
          checkOutput("out_byte", 32'(bus.OUT), 32'(v.exp_bytes[k]));
          checkOutput("out_last", 32'(bus.OUT_LAST), 32'(k == v.exp_len - 1));
          checkOutput("out_id", 32'(bus.OUT_ID), 32'(v.exp_gnt[1]));
          checkOutput("rom_addr", 32'(bus.ROM_ADDR), 32'(ea));
          if (k == v.stall_at && stalled < v.stall_n) begin
            bus.OUT_READY = 1'b0;
            stalled++;
          end else begin
            bus.OUT_READY = 1'b1;
            k++;
            last_hs = c;
          end
        end
      end
    end
    if (!got) checkOutput("done_timeout", 32'(0), 32'(1));
    bus.OUT_READY = 1'b1;
  endtask

  initial begin
    int  k;
    bit  reached;

    rom[0] = 8'd70;
    rom[1] = 8'd80;
    rom[2] = 8'd71;
    rom[3] = 8'd65;
    for (int i = 4; i < 16; i++) rom[i] = 8'hA0 + 8'(i);

    //            req    b0    l0    b1    l1    hold  gnt    len bytes                                       stall
    vecs[0]  = '{2'b11, 4'd0, 4'd1, 4'd3, 4'd1, 1'b0, 2'b01, 1, seq(8'd70, 8'd0, 8'd0, 8'd0),            -1, 0};
    vecs[1]  = '{2'b01, 4'd0, 4'd4, 4'd0, 4'd0, 1'b0, 2'b01, 4, seq(8'd65, 8'd71, 8'd80, 8'd70),         -1, 0};
    vecs[2]  = '{2'b11, 4'd2, 4'd1, 4'd5, 4'd1, 1'b1, 2'b10, 1, seq(8'hA5, 8'd0, 8'd0, 8'd0),            -1, 0};
    vecs[3]  = '{2'b11, 4'd2, 4'd1, 4'd5, 4'd1, 1'b1, 2'b01, 1, seq(8'd71, 8'd0, 8'd0, 8'd0),            -1, 0};
    vecs[4]  = '{2'b11, 4'd2, 4'd1, 4'd5, 4'd1, 1'b1, 2'b10, 1, seq(8'hA5, 8'd0, 8'd0, 8'd0),            -1, 0};
    vecs[5]  = '{2'b11, 4'd2, 4'd1, 4'd5, 4'd1, 1'b0, 2'b01, 1, seq(8'd71, 8'd0, 8'd0, 8'd0),            -1, 0};
    vecs[6]  = '{2'b10, 4'd0, 4'd0, 4'd7, 4'd0, 1'b0, 2'b10, 0, seq(8'd0, 8'd0, 8'd0, 8'd0),             -1, 0};
    vecs[7]  = '{2'b01, 4'd14, 4'd4, 4'd0, 4'd0, 1'b0, 2'b01, 4, seq(8'd80, 8'd70, 8'hAF, 8'hAE),        -1, 0};
    vecs[8]  = '{2'b10, 4'd0, 4'd0, 4'd8, 4'd2, 1'b0, 2'b10, 2, seq(8'hA9, 8'hA8, 8'd0, 8'd0),           -1, 0};
    vecs[9]  = '{2'b11, 4'd4, 4'd2, 4'd9, 4'd3, 1'b0, 2'b01, 2, seq(8'hA5, 8'hA4, 8'd0, 8'd0),           -1, 0};
    vecs[10] = '{2'b01, 4'd4, 4'd3, 4'd0, 4'd0, 1'b0, 2'b01, 3, seq(8'hA6, 8'hA5, 8'hA4, 8'd0),           1, 5};
    restart_vec = '{2'b01, 4'd0, 4'd4, 4'd0, 4'd0, 1'b0, 2'b01, 4, seq(8'd65, 8'd71, 8'd80, 8'd70),      -1, 0};

    rst_n         = 1'b0;
    bus.REQ       = 2'b11;
    bus.BASE0     = 4'd0;
    bus.LEN0      = 4'd1;
    bus.BASE1     = 4'd3;
    bus.LEN1      = 4'd1;
    bus.OUT_READY = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("rst_gnt", 32'(bus.GNT), 32'(0));
      checkOutput("rst_valid", 32'(bus.OUT_VALID), 32'(0));
      checkOutput("rst_out", 32'(bus.OUT), 32'(0));
      checkOutput("rst_last", 32'(bus.OUT_LAST), 32'(0));
      checkOutput("rst_id", 32'(bus.OUT_ID), 32'(0));
      checkOutput("rst_done", 32'(bus.DONE), 32'(0));
      checkOutput("rst_busy", 32'(bus.BUSY), 32'(0));
      checkOutput("rst_rom_addr", 32'(bus.ROM_ADDR), 32'(0));
    end
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) applyStimulus(vecs[i]);

    // Reset while the second of four bytes is waiting for a handshake.
    bus.REQ       = 2'b01;
    bus.BASE0     = 4'd0;
    bus.LEN0      = 4'd4;
    bus.OUT_READY = 1'b1;
    reached = 1'b0;
    k = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.GNT != 2'b00) bus.REQ = 2'b00;
      if (bus.OUT_VALID) begin
        if (k == 0) begin
          bus.OUT_READY = 1'b1;
          k++;
        end else begin
          checkOutput("mid_byte2", 32'(bus.OUT), 32'(8'd71));
          bus.OUT_READY = 1'b0;
          rst_n = 1'b0;
          reached = 1'b1;
          break;
        end
      end
    end
    checkOutput("mid_reached", 32'(reached), 32'(1));
    @(negedge clk);
    checkOutput("mid_valid", 32'(bus.OUT_VALID), 32'(0));
    checkOutput("mid_busy", 32'(bus.BUSY), 32'(0));
    checkOutput("mid_done", 32'(bus.DONE), 32'(0));
    checkOutput("mid_rom_addr", 32'(bus.ROM_ADDR), 32'(0));
    rst_n = 1'b1;
    bus.OUT_READY = 1'b1;
    @(negedge clk);
    checkOutput("mid_done_after", 32'(bus.DONE), 32'(0));
    checkOutput("mid_gnt_after", 32'(bus.GNT), 32'(0));
    applyStimulus(restart_vec);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
